// File: rtl/twiddle_pkg.sv
// Shared elaboration-time helpers for the MDC twiddle generator: size/period
// arithmetic and the quarter-wave cosine table builder.
package twiddle_pkg;

  localparam real PI = 3.14159265358979323846;

  function automatic int n_points(int n_log2);
    return 1 << n_log2;
  endfunction

  function automatic int quarter(int n_log2);
    return (1 << n_log2) >> 2;
  endfunction

  // Twiddles per period for stage s: N >> (s+1).
  function automatic int period(int n_log2, int s);
    return (1 << n_log2) >> (s + 1);
  endfunction

  // trunc(2^(w-2) * cos(2*pi*i/N)), truncated toward zero.
  function automatic int cos_entry(int i, int n_log2, int w);
    real ang;
    real scale;
    ang   = 2.0 * PI * $itor(i) / $itor(1 << n_log2);
    scale = $itor(1 << (w - 2));
    return $rtoi(scale * $cos(ang));
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Registered quarter-wave lookup: index in, (cos, sin) magnitudes out one cycle later.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int W      = 9
) (
  input  logic                     clk,
  input  logic [N_LOG2-3:0]        idx,
  output logic signed [W-1:0]      cos_q,
  output logic signed [W-1:0]      sin_q
);

  localparam int N4 = quarter(N_LOG2);

  logic signed [W-1:0] cos_tab [N4];
  logic signed [W-1:0] sin_tab [N4];

  // sin[i] = cos[N/4 - i] keeps a single quarter-wave of cosine as the source.
  for (genvar g = 0; g < N4; g++) begin : g_tab
    localparam int C = cos_entry(g, N_LOG2, W);
    localparam int S = (g == 0) ? 0 : cos_entry(N4 - g, N_LOG2, W);
    assign cos_tab[g] = W'(C);
    assign sin_tab[g] = W'(S);
  end

  always_ff @(posedge clk) begin
    cos_q <= cos_tab[idx];
    sin_q <= sin_tab[idx];
  end

endmodule

// File: rtl/twiddle_gen.sv
// Sequential twiddle-factor generator for one radix-2 MDC FFT stage:
// strided index counter, quarter-wave lookup, sign mapping, 2-cycle valid pipeline.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int W      = 9,
  parameter int STG_W  = $clog2(N_LOG2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [STG_W-1:0]     stage,
  input  logic                 inverse,
  input  logic                 en,
  output logic                 w_valid,
  output logic signed [W-1:0]  w_r,
  output logic signed [W-1:0]  w_i,
  output logic                 w_last,
  output logic                 busy
);

  localparam int KW = N_LOG2 - 1;
  localparam int IW = N_LOG2 - 2;
  localparam logic [STG_W-1:0] S_MAX = STG_W'(N_LOG2 - 1);

  logic [STG_W-1:0]    s_q;
  logic                inv_q;
  logic [KW-1:0]       k;
  logic [KW-1:0]       k_pm1;
  logic [KW-1:0]       e_nx;
  logic                accept;
  logic                v1;
  logic                last1;
  logic                quad1;
  logic signed [W-1:0] cos_v;
  logic signed [W-1:0] sin_v;
  logic signed [W-1:0] map_r;
  logic signed [W-1:0] map_i;

  always_comb begin
    accept = en & busy & ~start;
    k_pm1  = KW'(period(N_LOG2, int'(s_q)) - 1);
    e_nx   = k << s_q;
  end

  // The ROM register doubles as the first pipeline stage; only the quadrant
  // bit has to travel alongside it.
  twiddle_qrom #(
    .N_LOG2 (N_LOG2),
    .W      (W)
  ) u_qrom (
    .clk   (clk),
    .idx   (e_nx[IW-1:0]),
    .cos_q (cos_v),
    .sin_q (sin_v)
  );

  always_comb begin
    if (!quad1) begin
      map_r = cos_v;
      map_i = -sin_v;
    end else begin
      map_r = -sin_v;
      map_i = -cos_v;
    end
    if (inv_q) map_i = -map_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      s_q     <= '0;
      inv_q   <= 1'b0;
      k       <= '0;
      v1      <= 1'b0;
      last1   <= 1'b0;
      quad1   <= 1'b0;
      w_valid <= 1'b0;
      w_r     <= '0;
      w_i     <= '0;
      w_last  <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      s_q     <= (stage >= S_MAX) ? S_MAX : stage;
      inv_q   <= inverse;
      k       <= '0;
      v1      <= 1'b0;
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        quad1 <= e_nx[KW-1];
        last1 <= (k == k_pm1);
        k     <= (k == k_pm1) ? '0 : k + KW'(1);
      end
      w_valid <= v1;
      w_last  <= v1 & last1;
      if (v1) begin
        w_r <= map_r;
        w_i <= map_i;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Self-checking bench for twiddle_gen (N=32, W=9): timestamped scoreboard fed by
// a trigonometric reference, directed scenarios plus randomized en/start/rst traffic.
module tb_twiddle_gen;

  localparam int  N_LOG2 = 5;
  localparam int  W      = 9;
  localparam int  STG_W  = 3;
  localparam int  N      = 32;
  localparam real PI_TB  = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [STG_W-1:0]    stage = '0;
  logic                inverse = 1'b0;
  logic                en = 1'b0;
  logic                w_valid;
  logic signed [W-1:0] w_r;
  logic signed [W-1:0] w_i;
  logic                w_last;
  logic                busy;

  always #5 clk = ~clk;

  twiddle_gen #(
    .N_LOG2 (N_LOG2),
    .W      (W),
    .STG_W  (STG_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stage   (stage),
    .inverse (inverse),
    .en      (en),
    .w_valid (w_valid),
    .w_r     (w_r),
    .w_i     (w_i),
    .w_last  (w_last),
    .busy    (busy)
  );

  typedef struct {
    int due;
    int r;
    int i;
    bit last;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   busy_m = 1'b0;
  int   s_m = 0;
  bit   inv_m = 1'b0;
  int   k_m = 0;
  int   last_r = 0;
  int   last_i = 0;
  bit   rst_seen = 1'b1;
  int   got_r[64];
  int   got_i[64];
  int   got_l[64];
  int   rec_n = 0;
  bit   rec_on = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Full-circle reference: W = exp(-j*2*pi*e/N), conjugated for inverse.
  function automatic int ref_r(int e);
    return $rtoi($itor(1 << (W - 2)) * $cos(2.0 * PI_TB * $itor(e) / $itor(N)));
  endfunction

  function automatic int ref_i(int e, bit inv);
    int v;
    v = -$rtoi($itor(1 << (W - 2)) * $sin(2.0 * PI_TB * $itor(e) / $itor(N)));
    return inv ? -v : v;
  endfunction

  task automatic tick(input bit r_i, input bit s_i, input bit e_i, input int stg, input bit inv_i);
    bit   exp_valid;
    exp_t x;
    int   p;
    int   e;
    logic [31:0] stg_v;
    @(negedge clk);
    cyc++;
    exp_valid = (q.size() > 0) && (q[0].due == cyc);
    chk("w_valid", {31'b0, w_valid}, int'(exp_valid));
    if (exp_valid) begin
      x = q.pop_front();
      chk("w_r", w_r, x.r);
      chk("w_i", w_i, x.i);
      chk("w_last", {31'b0, w_last}, int'(x.last));
      last_r = x.r;
      last_i = x.i;
      if (rec_on && rec_n < 64) begin
        got_r[rec_n] = int'(w_r);
        got_i[rec_n] = int'(w_i);
        got_l[rec_n] = int'(w_last);
        rec_n++;
      end
    end else begin
      chk("hold_r", w_r, last_r);
      chk("hold_i", w_i, last_i);
    end
    chk("busy", {31'b0, busy}, int'(busy_m));
    if (rst_seen) begin
      chk("rst_w_last", {31'b0, w_last}, 0);
      rst_seen = 1'b0;
    end
    stg_v   = stg;
    rst     = r_i;
    start   = s_i;
    en      = e_i;
    stage   = stg_v[STG_W-1:0];
    inverse = inv_i;
    if (r_i) begin
      q.delete();
      busy_m = 1'b0; s_m = 0; inv_m = 1'b0; k_m = 0;
      last_r = 0; last_i = 0; rst_seen = 1'b1;
    end else if (s_i) begin
      q.delete();
      busy_m = 1'b1;
      s_m    = (stg > N_LOG2 - 1) ? N_LOG2 - 1 : stg;
      inv_m  = inv_i;
      k_m    = 0;
    end else if (e_i && busy_m) begin
      p = N >> (s_m + 1);
      e = k_m * (1 << s_m);
      q.push_back('{cyc + 2, ref_r(e), ref_i(e, inv_m), (k_m == p - 1)});
      k_m = (k_m + 1) % p;
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic run_en(input int n);
    for (int j = 0; j < n; j++) tick(1'b0, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic do_start(input int stg, input bit inv_i);
    tick(1'b0, 1'b1, 1'b1, stg, inv_i);
    rec_n  = 0;
    rec_on = 1'b1;
  endtask

  task automatic lit(input string tag, input int idx, input int r, input int i);
    chk({tag, "_r"}, got_r[idx], r);
    chk({tag, "_i"}, got_i[idx], i);
  endtask

  initial begin
    int stg_r;
    bit inv_r;
    tick(1'b1, 1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 0, 1'b0);

    // en before any start
    run_en(4);
    idle(3);

    // stage 0, forward, full period plus wrap
    do_start(0, 1'b0);
    run_en(18);
    idle(3);
    rec_on = 1'b0;
    lit("s0_k0", 0, 128, 0);
    lit("s0_k1", 1, 125, -24);
    lit("s0_k8", 8, 0, -128);
    lit("s0_k9", 9, -24, -125);
    lit("s0_k15", 15, -125, -24);
    chk("s0_k15_last", got_l[15], 1);
    lit("s0_k16", 16, 128, 0);
    chk("s0_k16_last", got_l[16], 0);

    // stage 1 forward
    do_start(1, 1'b0);
    run_en(9);
    idle(3);
    rec_on = 1'b0;
    lit("s1_k1", 1, 118, -48);
    lit("s1_k4", 4, 0, -128);
    lit("s1_k7", 7, -118, -48);
    chk("s1_k7_last", got_l[7], 1);

    // stage 1 inverse
    do_start(1, 1'b1);
    run_en(8);
    idle(3);
    rec_on = 1'b0;
    lit("s1i_k1", 1, 118, 48);
    lit("s1i_k5", 5, -48, 118);

    // last stage and clamped stage
    do_start(4, 1'b0);
    run_en(4);
    idle(3);
    do_start(7, 1'b1);
    run_en(4);
    idle(3);
    rec_on = 1'b0;
    lit("s7_k0", 0, 128, 0);
    chk("s7_last", got_l[3], 1);

    // en toggling
    do_start(2, 1'b0);
    rec_on = 1'b0;
    for (int j = 0; j < 12; j++) tick(1'b0, 1'b0, (j % 3) != 1, 0, 1'b0);
    idle(3);

    // reset mid-stream
    do_start(0, 1'b0);
    rec_on = 1'b0;
    run_en(5);
    tick(1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_en(3);
    idle(3);

    // restart mid-stream flushes in-flight words
    do_start(0, 1'b0);
    rec_on = 1'b0;
    run_en(7);
    do_start(0, 1'b0);
    run_en(3);
    idle(3);
    rec_on = 1'b0;
    lit("restart_k0", 0, 128, 0);
    lit("restart_k1", 1, 125, -24);

    // randomized traffic
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 99) == 0) begin
        tick(1'b1, 1'b0, $urandom_range(0, 1) == 1, 0, 1'b0);
      end else if ($urandom_range(0, 29) == 0) begin
        stg_r = $urandom_range(0, 7);
        inv_r = $urandom_range(0, 1) == 1;
        tick(1'b0, 1'b1, $urandom_range(0, 1) == 1, stg_r, inv_r);
      end else begin
        tick(1'b0, 1'b0, $urandom_range(0, 3) != 0, 0, 1'b0);
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
